// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_core
// Brief  : 8N1 UART receiver. It synchronises the pin, samples each bit at its
//          mid-point, and strobes good bytes or framing errors.
// Rev    : 1.0  initial release
// ============================================================================
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       uart_rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             w_fall;

  // Idle-high line: reset the flops to 1 so that leaving reset is never seen as a start edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx_pin;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign w_fall = prev_q & ~sync2_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (w_fall) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (sync2_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = sync2_q;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_STOP: begin
        // Leave at the stop-bit mid-point so a start edge in its second half is caught.
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (sync2_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_rx_core
// Brief  : Scoreboard bench for uart_rx_core, with directed and random 8N1 frames.
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_rx_core;

  localparam int CPB        = 16;
  localparam int HALF       = CPB / 2;
  localparam int STROBE_LAT = 3 + HALF + 9 * CPB;  // edges from pin fall to strobe

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       uart_rx_pin = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, rx_busy;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [7:0] last_good = 8'h00;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t sb_q[$];

  uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .uart_rx_pin  (uart_rx_pin),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line modelled as segments (0 start, 1..8 data, 9 stop, then idle). The receiver
  // looks at the pin as it stood HALF + n*CPB edges after the falling edge.
  function automatic exp_t predict(input logic [7:0] b, input bit stopb,
                                   input int line_cpb, input int start_cyc);
    logic seg [0:31];
    exp_t e;
    int   s;
    for (int i = 0; i < 32; i++) seg[i] = 1'b1;
    seg[0] = 1'b0;
    for (int k = 0; k < 8; k++) seg[k+1] = b[k];
    seg[9] = stopb;
    e.data = '0;
    for (int k = 0; k < 8; k++) begin
      s = (HALF + (k + 1) * CPB) / line_cpb;
      e.data[k] = seg[(s > 31) ? 31 : s];
    end
    s        = (HALF + 9 * CPB) / line_cpb;
    e.is_err = !seg[(s > 31) ? 31 : s];
    e.cyc    = start_cyc + STROBE_LAT;
    return e;
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit stopb,
                            input int line_cpb, input bit expect_it);
    logic [9:0] bits;
    bits = {stopb, b, 1'b0};
    if (expect_it) sb_q.push_back(predict(b, stopb, line_cpb, cyc));
    for (int i = 0; i < 10; i++) begin
      uart_rx_pin = bits[i];
      repeat (line_cpb) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    uart_rx_pin = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic busy_window(input int n, input int rise, input int fall);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rx_busy_window", rx_busy, (i >= rise && i < fall));
    end
  endtask

  task automatic chk_reset_outputs();
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_valid", rx_valid, 1'b0);
    chk("reset_rx_frame_err", rx_frame_err, 1'b0);
    chk("reset_rx_busy", rx_busy, 1'b0);
  endtask

  // Monitor: pops expectations whenever the DUT strobes, otherwise checks rx_data is held.
  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      chk("valid_err_exclusive", rx_valid & rx_frame_err, 1'b0);
      if (rx_valid || rx_frame_err) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: got valid=%0b err=%0b data=0x%0h, want none (cycle %0d)",
                   rx_valid, rx_frame_err, rx_data, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("strobe_kind_err", rx_frame_err, e.is_err);
          chk("strobe_cycle", cyc, e.cyc);
          if (e.is_err) begin
            chk("rx_data_kept_on_err", rx_data, last_good);
          end else begin
            chk("rx_data", rx_data, e.data);
            last_good = e.data;
          end
        end
      end else begin
        chk("rx_data_hold", rx_data, last_good);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", sb_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    bit         sb;
    bit         prev_err;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk);
    #1 rstn = 1'b1;
    idle(4);

    // 0x55 with busy window
    fork
      send_frame(8'h55, 1'b1, CPB, 1'b1);
      busy_window(160, 3, STROBE_LAT);
    join
    @(posedge clk);
    #1;
    idle(5);

    // back-to-back, no idle gap
    send_frame(8'hA3, 1'b1, CPB, 1'b1);
    send_frame(8'h0F, 1'b1, CPB, 1'b1);
    idle(10);

    // short low glitch: START then back to IDLE at the start check
    fork
      begin
        uart_rx_pin = 1'b0;
        repeat (4) @(posedge clk);
        #1 uart_rx_pin = 1'b1;
      end
      busy_window(14, 3, 3 + HALF);
    join
    @(posedge clk);
    #1;
    idle(5);

    // framing error, then line held low must not retrigger
    send_frame(8'h3C, 1'b0, CPB, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("busy_while_line_low", rx_busy, 1'b0);
    end
    @(posedge clk);
    #1;
    idle(6);
    send_frame(8'h5A, 1'b1, CPB, 1'b1);
    idle(10);

    // reset during data bit 4 of a 0xFF frame
    fork
      send_frame(8'hFF, 1'b1, CPB, 1'b0);
      begin
        repeat (HALF + 5 * CPB) @(posedge clk);
        #3;
        rstn      = 1'b0;
        last_good = 8'h00;
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #3 rstn = 1'b1;
      end
    join
    idle(10);
    send_frame(8'h81, 1'b1, CPB, 1'b1);
    idle(10);

    // line-rate skew
    send_frame(8'hC6, 1'b1, 15, 1'b1);
    idle(20);
    send_frame(8'hC6, 1'b1, 17, 1'b1);
    idle(20);

    // random frames with random gaps and occasional bad stop bits
    prev_err = 1'b0;
    for (int i = 0; i < 24; i++) begin
      b  = 8'($urandom);
      sb = ($urandom_range(0, 4) != 0);
      idle(prev_err ? int'($urandom_range(2, 8)) : int'($urandom_range(0, 8)));
      send_frame(b, sb, CPB, 1'b1);
      prev_err = !sb;
    end
    idle(20);

    for (int t = 0; t < 400 && sb_q.size() > 0; t++) @(posedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
